seq_bcd_formatter: RTL and testbench

//  Multi-channel sequential binary-to-BCD converter for the stopwatch/clock displays.

---
 rtl/seq_bcd_formatter.sv | 216 +++++++++++++++++++++
 tb/tb_seq_bcd_formatter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_bcd_formatter.sv
// seq_bcd_formatter
//   Multi-channel sequential binary-to-BCD converter for the stopwatch/clock
//   displays. Channels are converted one after another with iterative
//   shift-add-3 (double dabble), one input bit per clock. Results go to a
//   shadow buffer and are published to bcd_out in one step, so the display
//   never sees a half-converted value. Leading-zero blanking (4'hA) can be
//   enabled per channel.
//
// Ports
//   mili_clk   in   1               system clock, rising edge
//   reset      in   1               asynchronous active-high reset
//   start      in   1               conversion request, sampled only in IDLE
//   bin_in     in   N_CH*BIN_W      channel c at [c*BIN_W +: BIN_W]
//   busy       out  1               conversion in progress (includes done cycle)
//   done       out  1               one-cycle pulse, bcd_out/ovf updated with it
//   bcd_out    out  N_CH*DIGITS*4   channel c digit d at [(c*DIGITS+d)*4 +: 4]
//   ovf        out  N_CH            per-channel saturation flag
//   dbg_state  out  3               current FSM state (state_t encoding)
//
// Handshake: a request is taken when start=1 while the FSM is in IDLE; any
// start seen in another state is dropped. busy rises the cycle after the
// request is taken and stays high through the done pulse.
//
// Build option: SATURATE_EN -- when defined, values above 10^DIGITS-1
// saturate to all nines and set ovf; when undefined the upper digits are
// dropped and ovf is held at zero.

module seq_bcd_formatter #(
  parameter int              N_CH        = 3,
  parameter int              BIN_W       = 7,
  parameter int              DIGITS      = 2,
  parameter logic [N_CH-1:0] BLANK_MASK  = N_CH'(3'b011),
  parameter logic [N_CH-1:0] ZBLANK_MASK = N_CH'(3'b001)
) (
  input  logic                     mili_clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [N_CH*BIN_W-1:0]    bin_in,
  output logic                     busy,
  output logic                     done,
  output logic [N_CH*DIGITS*4-1:0] bcd_out,
  output logic [N_CH-1:0]          ovf,
  output logic [2:0]               dbg_state
);

  // Number of BCD digits needed to hold 2^bw-1 exactly.
  function automatic int calc_int_dig(input int bw);
    longint max_v;
    longint pow_v;
    int     dig_n;
    max_v = (longint'(1) << bw) - 1;
    pow_v = 1;
    dig_n = 0;
    for (int i = 0; i < 20; i++) begin
      if (pow_v <= max_v) begin
        pow_v = pow_v * 10;
        dig_n = dig_n + 1;
      end
    end
    return dig_n;
  endfunction

  localparam int INT_DIG = calc_int_dig(BIN_W);
  localparam int ACC_W   = INT_DIG * 4;
  localparam int PAD_DIG = (INT_DIG > DIGITS) ? INT_DIG : DIGITS;
  localparam int PAD_W   = PAD_DIG * 4;
  localparam int CNT_W   = $clog2(BIN_W + 1);
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                   state_q;
  logic [CH_W-1:0]          ch_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [BIN_W-1:0]         sreg_q;
  logic [ACC_W-1:0]         acc_q;
  logic [N_CH*BIN_W-1:0]    bin_q;
  logic [N_CH*DIGITS*4-1:0] shadow_q;
  logic [N_CH*DIGITS*4-1:0] bcd_q;
  logic                     busy_q;
  logic                     done_q;

  logic [DIGITS*4-1:0]      store_dig_d;
  logic [PAD_W-1:0]         acc_pad;
  logic [3:0]               dig_v;
  logic                     seen_nz;

  // One double-dabble step: correct every nibble >= 5, then shift in the next bit.
  function automatic logic [ACC_W-1:0] dabble_step(input logic [ACC_W-1:0] a,
                                                   input logic             b);
    logic [ACC_W-1:0] t;
    t = a;
    for (int i = 0; i < INT_DIG; i++) begin
      if (t[i*4 +: 4] >= 4'd5) t[i*4 +: 4] = t[i*4 +: 4] + 4'd3;
    end
    return {t[ACC_W-2:0], b};
  endfunction

`ifdef SATURATE_EN
  logic [N_CH-1:0] shadow_ovf_q;
  logic [N_CH-1:0] ovf_q;
  logic            store_ovf_d;
`endif

  // Formatting of the finished accumulator for the channel in ch_q.
  always_comb begin
    store_dig_d = '0;
    acc_pad     = PAD_W'(acc_q);
    dig_v       = '0;
    seen_nz     = 1'b0;
    // Scan from the most significant digit; zeros are blanked until the
    // first non-zero digit. The ones digit is never blanked here.
    for (int d = DIGITS - 1; d >= 0; d--) begin
      dig_v = acc_pad[d*4 +: 4];
      if (BLANK_MASK[ch_q] && (d > 0) && !seen_nz && (dig_v == 4'd0)) begin
        store_dig_d[d*4 +: 4] = 4'hA;
      end else begin
        store_dig_d[d*4 +: 4] = dig_v;
        seen_nz               = 1'b1;
      end
    end
    // Zero value on a zero-blank channel shows nothing at all.
    if (BLANK_MASK[ch_q] && ZBLANK_MASK[ch_q] && (acc_q == '0)) begin
      store_dig_d[3:0] = 4'hA;
    end
`ifdef SATURATE_EN
    // Any accumulator digit above the displayed ones means overflow.
    store_ovf_d = 1'b0;
    for (int d = DIGITS; d < PAD_DIG; d++) begin
      if (acc_pad[d*4 +: 4] != 4'd0) store_ovf_d = 1'b1;
    end
    if (store_ovf_d) store_dig_d = {DIGITS{4'h9}};
`endif
  end

  always_ff @(posedge mili_clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      cnt_q    <= '0;
      sreg_q   <= '0;
      acc_q    <= '0;
      bin_q    <= '0;
      shadow_q <= '0;
      bcd_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SATURATE_EN
      shadow_ovf_q <= '0;
      ovf_q        <= '0;
`endif
    end else begin
      // busy covers LOAD through the done pulse; done follows the DONE state.
      busy_q <= (state_q != S_IDLE);
      done_q <= (state_q == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            bin_q   <= bin_in;
            ch_q    <= '0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          sreg_q  <= bin_q[ch_q*BIN_W +: BIN_W];
          acc_q   <= '0;
          cnt_q   <= CNT_W'(BIN_W);
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          acc_q  <= dabble_step(acc_q, sreg_q[BIN_W-1]);
          sreg_q <= sreg_q << 1;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= S_STORE;
        end
        S_STORE: begin
          shadow_q[ch_q*DIGITS*4 +: DIGITS*4] <= store_dig_d;
`ifdef SATURATE_EN
          shadow_ovf_q[ch_q] <= store_ovf_d;
`endif
          if (ch_q == CH_W'(N_CH - 1)) begin
            state_q <= S_DONE;
          end else begin
            ch_q    <= ch_q + CH_W'(1);
            state_q <= S_LOAD;
          end
        end
        S_DONE: begin
          bcd_q <= shadow_q;
`ifdef SATURATE_EN
          ovf_q <= shadow_ovf_q;
`endif
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign bcd_out   = bcd_q;
  assign dbg_state = state_q;
`ifdef SATURATE_EN
  assign ovf = ovf_q;
`else
  assign ovf = '0;
`endif

endmodule

// File: tb/tb_seq_bcd_formatter.sv
// Testbench for seq_bcd_formatter: default 3-channel instance plus a
// 1-channel 12-bit / 4-digit instance. Directed vectors with hand-computed
// BCD results; expected values depend on SATURATE_EN where relevant.

module tb_seq_bcd_formatter;

  // ---------------- clock / reset ----------------
  logic mili_clk;
  logic reset;

  initial begin
    mili_clk = 1'b0;
    forever #5 mili_clk = ~mili_clk;
  end

  // ---------------- DUT A: defaults ----------------
  logic        start_a;
  logic [20:0] bin_a;
  logic        busy_a;
  logic        done_a;
  logic [23:0] bcd_a;
  logic [2:0]  ovf_a;
  logic [2:0]  dbg_a;

  seq_bcd_formatter u_dut_a (
    .mili_clk (mili_clk),
    .reset    (reset),
    .start    (start_a),
    .bin_in   (bin_a),
    .busy     (busy_a),
    .done     (done_a),
    .bcd_out  (bcd_a),
    .ovf      (ovf_a),
    .dbg_state(dbg_a)
  );

  // ---------------- DUT B: 1 channel, 12 bit, 4 digits ----------------
  logic        start_b;
  logic [11:0] bin_b;
  logic        busy_b;
  logic        done_b;
  logic [15:0] bcd_b;
  logic [0:0]  ovf_b;
  logic [2:0]  dbg_b;

  seq_bcd_formatter #(
    .N_CH       (1),
    .BIN_W      (12),
    .DIGITS     (4),
    .BLANK_MASK (1'b0),
    .ZBLANK_MASK(1'b0)
  ) u_dut_b (
    .mili_clk (mili_clk),
    .reset    (reset),
    .start    (start_b),
    .bin_in   (bin_b),
    .busy     (busy_b),
    .done     (done_b),
    .bcd_out  (bcd_b),
    .ovf      (ovf_b),
    .dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  logic [26:0] exp_q[$];     // {ovf, bcd} expected for DUT A
  logic [23:0] model_bcd;    // what bcd_a must show between done pulses
  logic [2:0]  model_ovf;
  int          n_checks;
  int          n_fail;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One conversion on DUT A. glitch_at > 0 pulses start with other data
  // that many cycles into the conversion.
  task automatic run_a(input string tag, input logic [6:0] c2, input logic [6:0] c1,
                       input logic [6:0] c0, input logic [23:0] exp_bcd,
                       input logic [2:0] exp_ovf, input int glitch_at);
    int          lat;
    int          busy_cnt;
    bit          stable;
    logic [26:0] exp_v;
    exp_q.push_back({exp_ovf, exp_bcd});
    @(negedge mili_clk);
    start_a = 1'b1;
    bin_a   = {c2, c1, c0};
    @(negedge mili_clk);
    start_a  = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    stable   = 1'b1;
    while (done_a !== 1'b1 && lat < 100) begin
      if (glitch_at > 0 && lat == glitch_at) begin
        start_a = 1'b1;
        bin_a   = 21'h1F_FFFF;
      end else begin
        start_a = 1'b0;
      end
      @(negedge mili_clk);
      lat++;
      if (busy_a === 1'b1) busy_cnt++;
      if (done_a !== 1'b1 && (bcd_a !== model_bcd || ovf_a !== model_ovf)) stable = 1'b0;
    end
    start_a = 1'b0;
    check_eq({tag, "_latency"}, 64'(lat), 64'd28);
    check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd28);
    check_eq({tag, "_hold_prev"}, 64'(stable), 64'd1);
    exp_v = exp_q.pop_front();
    check_eq({tag, "_bcd"}, 64'(bcd_a), 64'(exp_v[23:0]));
    check_eq({tag, "_ovf"}, 64'(ovf_a), 64'(exp_v[26:24]));
    model_bcd = exp_v[23:0];
    model_ovf = exp_v[26:24];
    @(negedge mili_clk);
    check_eq({tag, "_done_pulse"}, 64'(done_a), 64'd0);
    check_eq({tag, "_idle_after"}, 64'(busy_a), 64'd0);
  endtask

  task automatic run_b(input string tag, input logic [11:0] val, input logic [15:0] exp_bcd);
    int lat;
    @(negedge mili_clk);
    start_b = 1'b1;
    bin_b   = val;
    @(negedge mili_clk);
    start_b = 1'b0;
    lat     = 0;
    while (done_b !== 1'b1 && lat < 100) begin
      @(negedge mili_clk);
      lat++;
    end
    check_eq({tag, "_latency"}, 64'(lat), 64'd15);
    check_eq({tag, "_bcd"}, 64'(bcd_b), 64'(exp_bcd));
    check_eq({tag, "_ovf"}, 64'(ovf_b), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_bcd"}, 64'(bcd_a), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy_a), 64'd0);
    check_eq({tag, "_done"}, 64'(done_a), 64'd0);
    check_eq({tag, "_ovf"}, 64'(ovf_a), 64'd0);
    check_eq({tag, "_state"}, 64'(dbg_a), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    model_bcd = '0;
    model_ovf = '0;
    reset     = 1'b1;
    start_a   = 1'b0;
    bin_a     = '0;
    start_b   = 1'b0;
    bin_b     = '0;
    repeat (2) @(negedge mili_clk);
    check_reset_state("por");
    reset = 1'b0;

    // ch2=0 (unblanked), ch1=5 (blanked tens), ch0=37
    run_a("basic", 7'd0, 7'd5, 7'd37, 24'h00_A5_37, 3'b000, 0);

    // asynchronous reset while idle clears outputs before any clock edge
    @(negedge mili_clk);
    reset = 1'b1;
    #1;
    check_reset_state("idle_rst");
    model_bcd = '0;
    model_ovf = '0;
    @(negedge mili_clk);
    reset = 1'b0;

    // zero handling: ch0 fully blanked, ch1 keeps its ones digit
    run_a("zeros", 7'd59, 7'd0, 7'd0, 24'h59_A0_AA, 3'b000, 0);

`ifdef SATURATE_EN
    run_a("big1", 7'd9,   7'd100, 7'd127, 24'h09_99_99, 3'b011, 0);
    run_a("big2", 7'd127, 7'd10,  7'd99,  24'h99_10_99, 3'b100, 0);
    run_a("big3", 7'd60,  7'd1,   7'd100, 24'h60_A1_99, 3'b001, 0);
`else
    run_a("big1", 7'd9,   7'd100, 7'd127, 24'h09_A0_27, 3'b000, 0);
    run_a("big2", 7'd127, 7'd10,  7'd99,  24'h27_10_99, 3'b000, 0);
    run_a("big3", 7'd60,  7'd1,   7'd100, 24'h60_A1_A0, 3'b000, 0);
`endif

    // start pulse with new data mid-conversion must be ignored
    run_a("glitch", 7'd3, 7'd7, 7'd42, 24'h03_A7_42, 3'b000, 5);

    // reset during the third SHIFT cycle aborts the conversion
    @(negedge mili_clk);
    start_a = 1'b1;
    bin_a   = {7'd88, 7'd77, 7'd66};
    @(negedge mili_clk);
    start_a = 1'b0;
    repeat (3) @(negedge mili_clk);
    reset = 1'b1;
    #1;
    check_reset_state("abort_rst");
    model_bcd = '0;
    model_ovf = '0;
    @(negedge mili_clk);
    reset = 1'b0;
    run_a("after_abort", 7'd12, 7'd34, 7'd56, 24'h12_34_56, 3'b000, 0);

    // wide single-channel instance
    run_b("w4095", 12'd4095, 16'h4095);
    run_b("w5",    12'd5,    16'h0005);
    run_b("w1000", 12'd1000, 16'h1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
